nios_pio_gen: RTL and testbench

//  Parametrised Avalon-MM general-purpose I/O slave for the Nios system; supersedes fixed-width output-only PIOs.
//  Per-bit direction, atomic set/clear of output bits, 2-flop input synchroniser, edge capture, masked level IRQ.

---
 rtl/nios_pio_gen.sv | 121 ++++++++++++
 tb/tb_nios_pio_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_gen.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear of outputs,
// 2-flop input synchroniser, configurable edge capture and masked level IRQ.
module nios_pio_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [31:0] DATA_RESET = 32'h0,
  parameter logic [31:0] DIR_RESET  = 32'h0,
  parameter int unsigned EDGE_TYPE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en
);

  localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(DATA_RESET);
  localparam logic [WIDTH-1:0] DIR_RST  = WIDTH'(DIR_RESET);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q,      dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] sync1_q,    sync1_d;
  logic [WIDTH-1:0] in_sync_q,  in_sync_d;
  logic [WIDTH-1:0] in_prev_q,  in_prev_d;

  logic             wr_c;
  logic [WIDTH-1:0] wd_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] rd_c;
  logic             wd_unused_c;

  assign wr_c        = chipselect & ~write_n;
  assign wd_c        = writedata[WIDTH-1:0];
  assign wd_unused_c = ^writedata;

  // Edge select on the synchronised pin against its previous sample
  always_comb begin
    edge_c = '0;
    case (EDGE_TYPE)
      0:       edge_c = in_sync_q & ~in_prev_q;
      1:       edge_c = ~in_sync_q & in_prev_q;
      default: edge_c = in_sync_q ^ in_prev_q;
    endcase
  end

  // Register writes and input pipeline; a fresh edge overrides a same-cycle clear
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    clr_c      = '0;
    sync1_d    = in_port;
    in_sync_d  = sync1_q;
    in_prev_d  = in_sync_q;
    if (wr_c) begin
      case (address)
        A_DATA:    data_out_d = wd_c;
        A_DIR:     dir_d      = wd_c;
        A_IRQMASK: irq_mask_d = wd_c;
        A_EDGECAP: clr_c      = wd_c;
        A_OUTSET:  data_out_d = data_out_q | wd_c;
        A_OUTCLR:  data_out_d = data_out_q & ~wd_c;
        default:   ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~clr_c) | edge_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= DATA_RST;
      dir_q      <= DIR_RST;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      sync1_q    <= '0;
      in_sync_q  <= '0;
      in_prev_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      sync1_q    <= sync1_d;
      in_sync_q  <= in_sync_d;
      in_prev_q  <= in_prev_d;
    end
  end

  // Zero-wait-state read mux, independent of chipselect
  always_comb begin
    rd_c = '0;
    case (address)
      A_DATA:    rd_c = (dir_q & data_out_q) | (~dir_q & in_sync_q);
      A_DIR:     rd_c = dir_q;
      A_IRQMASK: rd_c = irq_mask_q;
      A_EDGECAP: rd_c = edge_cap_q;
      default:   rd_c = '0;
    endcase
  end

  assign readdata = 32'(rd_c);
  assign irq      = |(edge_cap_q & irq_mask_q);
  assign out_port = data_out_q;
  assign out_en   = dir_q;

endmodule

// File: tb/tb_nios_pio_gen.sv
// Bench for nios_pio_gen: three instances (rising/falling/any edge) on one bus,
// checked every cycle against a pin-history model plus literal scenario checks.
module tb_nios_pio_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'h00;

  logic [31:0] rd [3];
  logic        irq_o [3];
  logic [7:0]  outp [3];
  logic [7:0]  oen [3];

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  nios_pio_gen #(.WIDTH(8), .DATA_RESET(32'h00), .DIR_RESET(32'h0F), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .irq(irq_o[0]),
    .in_port(in_port), .out_port(outp[0]), .out_en(oen[0]));
  nios_pio_gen #(.WIDTH(8), .DATA_RESET(32'h00), .DIR_RESET(32'h0F), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .irq(irq_o[1]),
    .in_port(in_port), .out_port(outp[1]), .out_en(oen[1]));
  nios_pio_gen #(.WIDTH(8), .DATA_RESET(32'h00), .DIR_RESET(32'h0F), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .irq(irq_o[2]),
    .in_port(in_port), .out_port(outp[2]), .out_en(oen[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register file plus the pin value seen at the last three clock edges
  logic [7:0] m_data, m_dir, m_mask;
  logic [7:0] m_cap [3];
  logic [7:0] h0, h1, h2;

  function automatic logic [7:0] edges(input int t, input logic [7:0] cur, input logic [7:0] prev);
    if (t == 0) return cur & ~prev;
    if (t == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  function automatic logic [7:0] clr_now();
    if (chipselect && !write_n && address == 3'd3) return writedata[7:0];
    return 8'h00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= 8'h00;
      m_dir  <= 8'h0F;
      m_mask <= 8'h00;
      for (int i = 0; i < 3; i++) m_cap[i] <= 8'h00;
      h0 <= 8'h00;
      h1 <= 8'h00;
      h2 <= 8'h00;
    end else begin
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[7:0];
          3'd1: m_dir  <= writedata[7:0];
          3'd2: m_mask <= writedata[7:0];
          3'd4: m_data <= m_data | writedata[7:0];
          3'd5: m_data <= m_data & ~writedata[7:0];
          default: ;
        endcase
      end
      for (int i = 0; i < 3; i++)
        m_cap[i] <= (m_cap[i] & ~clr_now()) | edges(i, h1, h2);
      h2 <= h1;
      h1 <= h0;
      h0 <= in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input int i);
    case (address)
      3'd0: return {24'h0, (m_dir & m_data) | (~m_dir & h1)};
      3'd1: return {24'h0, m_dir};
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_cap[i]};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_readdata_a%0d", i, address), rd[i], exp_rd(i));
        chk($sformatf("u%0d_out_port", i), {24'h0, outp[i]}, {24'h0, m_data});
        chk($sformatf("u%0d_out_en", i), {24'h0, oen[i]}, {24'h0, m_dir});
        chk($sformatf("u%0d_irq", i), {31'h0, irq_o[i]}, {31'h0, |(m_cap[i] & m_mask)});
      end
    end
  end

  // Write occupies one clock; called and returns at posedge+2
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd_chk(input int i, input logic [2:0] a, input logic [31:0] exp, input string nm);
    address = a;
    #1;
    chk(nm, rd[i], exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    run_chk = 1'b1;
    step(2);
    reset_n = 1'b1;

    rd_chk(0, 3'd1, 32'h0000000F, "t1_dir_reset");
    chk("t1_irq_reset", {31'h0, irq_o[0]}, 32'h0);
    in_port = 8'hA0;
    step(3);
    rd_chk(0, 3'd0, 32'h000000A0, "t1_data_in");

    wr(3'd0, 32'h5A);
    chk("t2_out_5a", {24'h0, outp[0]}, 32'h5A);
    wr(3'd4, 32'h81);
    chk("t2_out_db", {24'h0, outp[0]}, 32'hDB);
    wr(3'd5, 32'h02);
    chk("t2_out_d9", {24'h0, outp[0]}, 32'hD9);
    rd_chk(0, 3'd0, 32'h000000A9, "t2_read_mix");

    in_port[4] = 1'b1;
    step(2);
    rd_chk(0, 3'd3, 32'h000000A0, "t3_cap_k1");
    step(1);
    rd_chk(0, 3'd3, 32'h000000B0, "t3_cap_k2");
    chk("t3_irq_masked", {31'h0, irq_o[0]}, 32'h0);
    wr(3'd2, 32'h10);
    chk("t3_irq_unmask", {31'h0, irq_o[0]}, 32'h1);

    wr(3'd3, 32'hFF);
    rd_chk(0, 3'd3, 32'h0, "t4_w1c");
    chk("t4_irq_clr", {31'h0, irq_o[0]}, 32'h0);
    in_port[4] = 1'b0;
    step(3);
    in_port[4] = 1'b1;
    step(2);
    wr(3'd3, 32'h10);
    rd_chk(0, 3'd3, 32'h10, "t4_edge_wins");
    chk("t4_irq_edge_wins", {31'h0, irq_o[0]}, 32'h1);

    wr(3'd3, 32'hFF);
    in_port[5] = 1'b0;
    step(4);
    rd_chk(0, 3'd3, 32'h0,  "t5_rise_nofall");
    rd_chk(1, 3'd3, 32'h20, "t5_fall_cap");
    rd_chk(2, 3'd3, 32'h20, "t5_any_cap");

    in_port = ~in_port;
    step(4);
    rd_chk(2, 3'd3, 32'hFF, "t6_cap_ff");
    address = 3'd0;
    writedata = 32'h33;
    chipselect = 1'b1;
    write_n = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out", {24'h0, outp[0]}, 32'h0);
    chk("t6_rst_dir", {24'h0, oen[2]}, 32'h0F);
    chk("t6_rst_irq", {31'h0, irq_o[2]}, 32'h0);
    address = 3'd3;
    #1;
    chk("t6_rst_cap", rd[2], 32'h0);
    step(1);
    chipselect = 1'b0;
    write_n = 1'b1;
    reset_n = 1'b1;
    chk("t6_write_in_reset", {24'h0, outp[0]}, 32'h0);
    rd_chk(0, 3'd6, 32'h0, "t6_rsvd6");
    rd_chk(0, 3'd7, 32'h0, "t6_rsvd7");
    wr(3'd6, 32'hFF);
    wr(3'd7, 32'hFF);
    chk("t6_rsvd_out", {24'h0, outp[0]}, 32'h0);
    chk("t6_rsvd_dir", {24'h0, oen[0]}, 32'h0F);
    rd_chk(0, 3'd2, 32'h0, "t6_rsvd_mask");

    repeat (3000) begin
      @(posedge clk);
      #2;
      reset_n    = ($urandom_range(0, 599) != 0);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
    end
    reset_n = 1'b1;
    chipselect = 1'b0;
    write_n = 1'b1;
    step(2);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
